aes_key_sched: RTL and testbench
================================

Name: aes_key_sched

Overview:
- Run-time AES-128 key expansion unit with a loadable cipher key, replacing the fixed round-key ROM.
- Accepts a 128-bit cipher key, computes the 11 round keys at one per cycle, and stores them in NUM_SLOTS independent key contexts.
- The AES datapath reads round keys combinationally by slot and round index.
- Sits between the CPU-side key register interface and the AES round datapath.

Parameters:
- NUM_SLOTS, 2, number of independent key contexts (1..8).
- SLOT_W, (NUM_SLOTS>1 ? $clog2(NUM_SLOTS) : 1), slot index width. Derived; not overridden.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- load_v_i  in  1  key load request.
- load_slot_i  in  SLOT_W  target slot for the load.
- load_key_i  in  128  cipher key; bit 127 is byte 0 of the FIPS-197 key.
- load_ready_o  out  1  high when a load can be accepted.
- busy_o  out  1  high while an expansion is in progress.
- slot_valid_o  out  NUM_SLOTS  bit s high when slot s holds a complete schedule.
- rd_slot_i  in  SLOT_W  read slot.
- rd_round_i  in  4  read round index, 0..10.
- rd_key_o  out  128  round key, combinational from storage.
- rd_v_o  out  1  rd_key_o is a valid completed round key.

Behaviour:
- Storage: NUM_SLOTS x 11 x 128-bit registers.
- Reset values:
  - All storage is 0.
  - slot_valid_o = 0, busy_o = 0, load_ready_o = 1.
  - FSM is in IDLE and the round counter is 0.
- FSM states: IDLE, EXPAND.
- IDLE:
  - load_ready_o = 1.
  - When load_v_i is high, the load is accepted on that edge:
    - round 0 of the target slot is written with load_key_i;
    - slot_valid bit for that slot is cleared;
    - the target slot is latched and the round counter is set to 1;
    - the FSM goes to EXPAND.
- EXPAND:
  - load_ready_o = 0, busy_o = 1.
  - Each cycle computes round r from round r-1 and writes it:
    - t = SubWord(RotWord(w3)) ^ Rcon[r];
    - w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2';
    - w0 is bits 127:96.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36, placed in the top byte of t.
  - SubWord uses four combinational forward S-box lookups.
  - When r = 10 is written, the slot_valid bit is set on the same edge and the FSM returns to IDLE.
- Latency:
  - Load accepted on edge 0; round r written on edge r.
  - slot_valid and load_ready_o are visible after edge 10.
  - A back-to-back load can be accepted on edge 11.
- Loads asserted while load_ready_o = 0 are ignored. They are not queued; the requester must hold load_v_i.
- Reload of a valid slot:
  - the slot's valid bit drops on the acceptance edge;
  - rounds 1..10 of that slot keep their old values until overwritten.
- Read path:
  - rd_key_o = storage[rd_slot_i][rd_round_i] for rd_round_i <= 10.
  - rd_round_i 11..15 returns round 0 of the slot.
  - rd_v_o = slot_valid[rd_slot_i] & (rd_round_i <= 10).
  - rd_slot_i >= NUM_SLOTS gives rd_key_o = 0 and rd_v_o = 0.
- A read of the slot under expansion returns current storage contents with rd_v_o = 0.
- Reads of other slots are unaffected by an expansion in progress.
- Reset mid-expansion aborts immediately and all state returns to reset values.

Optional Feature:
- Macro: AES_KEY_SCHED_DEFAULT_KEY_EN.
- Defined:
  - Reset loads slot 0 with the FIPS-197 Appendix A.1 schedule for key 2B7E151628AED2A6ABF7158809CF4F3C.
  - Round 10 of that schedule is D014F9A8C9EE2589E13F0CC8B6630CA6.
  - slot_valid_o[0] = 1 out of reset; all other slots are as in normal reset.
- Undefined: all slots reset to 0 and invalid.

Test Plan:
- Load 2B7E151628AED2A6ABF7158809CF4F3C into slot 0:
  - slot_valid_o[0] rises 10 cycles after acceptance;
  - round 1 = A0FAFE1788542CB123A339392A6C7605;
  - round 5 = D4D1C6F87C839D87CAF2B8BC11F915BC;
  - round 10 = D014F9A8C9EE2589E13F0CC8B6630CA6.
- Load an all-zero key into slot 1:
  - round 1 = 62636363626363636263636362636363;
  - round 10 = B4EF5BCB3E92E21123E951CF6F8F188E;
  - slot 0 reads are unchanged throughout.
- Pulse load_v_i at cycle 3 of an expansion with a different key: it is ignored and the schedule matches the first key; a load held until ready is accepted on edge 11.
- Assert reset_i at round 6 of an expansion: all outputs return to reset values asynchronously, with no slot valid; a fresh load afterwards completes normally.
- Read rd_round_i = 12 on valid slot 0: rd_key_o = round 0 key and rd_v_o = 0; rd_slot_i beyond NUM_SLOTS gives 0 and rd_v_o = 0.
- With AES_KEY_SCHED_DEFAULT_KEY_EN defined: immediately after reset, slot 0 round 9 = AC7766F319FADC2128D12941575C006E and rd_v_o = 1.

Source files
------------

// File: rtl/aes_key_sched.sv
// AES-128 key expansion into NUM_SLOTS contexts, one round key per cycle; load accepted on edge 0, slot valid after edge 10.
// Loads while busy are dropped, not queued. AES_KEY_SCHED_DEFAULT_KEY_EN preloads slot 0 with the FIPS-197 A.1 schedule at reset.
module aes_key_sched #(
  parameter int NUM_SLOTS = 2,
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_v_i,
  input  logic [SLOT_W-1:0]    load_slot_i,
  input  logic [127:0]         load_key_i,
  output logic                 load_ready_o,
  output logic                 busy_o,
  output logic [NUM_SLOTS-1:0] slot_valid_o,
  input  logic [SLOT_W-1:0]    rd_slot_i,
  input  logic [3:0]           rd_round_i,
  output logic [127:0]         rd_key_o,
  output logic                 rd_v_o
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef AES_KEY_SCHED_DEFAULT_KEY_EN
  localparam logic [127:0] DEFAULT_SCHED [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
`endif

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t            state;
  logic [3:0]        round;
  logic [SLOT_W-1:0] cur_slot;
  logic [127:0]      keys [NUM_SLOTS][11];

  // Slot indices that map to real storage; guards non-power-of-two NUM_SLOTS.
  logic [(1<<SLOT_W)-1:0] slot_exists;
  always_comb begin
    slot_exists = '0;
    for (int s = 0; s < (1 << SLOT_W); s++) slot_exists[s] = (s < NUM_SLOTS);
  end

  logic [127:0] prev_key, next_key;
  logic [31:0]  w0, w1, w2, w3, t, n0, n1, n2, n3;
  always_comb begin
    prev_key = keys[cur_slot][(round == 4'd0) ? 4'd0 : round - 4'd1];
    {w0, w1, w2, w3} = prev_key;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rcon(round), 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      round        <= 4'd0;
      cur_slot     <= '0;
      load_ready_o <= 1'b1;
      busy_o       <= 1'b0;
      slot_valid_o <= '0;
      for (int s = 0; s < NUM_SLOTS; s++)
        for (int r = 0; r < 11; r++) keys[s][r] <= '0;
`ifdef AES_KEY_SCHED_DEFAULT_KEY_EN
      for (int r = 0; r < 11; r++) keys[0][r] <= DEFAULT_SCHED[r];
      slot_valid_o[0] <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load_v_i) begin
            if (slot_exists[load_slot_i]) begin
              keys[load_slot_i][0]        <= load_key_i;
              slot_valid_o[load_slot_i]   <= 1'b0;
            end
            cur_slot     <= load_slot_i;
            round        <= 4'd1;
            state        <= EXPAND;
            load_ready_o <= 1'b0;
            busy_o       <= 1'b1;
          end
        end
        EXPAND: begin
          if (slot_exists[cur_slot]) keys[cur_slot][round] <= next_key;
          if (round == 4'd10) begin
            if (slot_exists[cur_slot]) slot_valid_o[cur_slot] <= 1'b1;
            round        <= 4'd0;
            state        <= IDLE;
            load_ready_o <= 1'b1;
            busy_o       <= 1'b0;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Out-of-range rounds alias round 0 but never report valid.
  logic [3:0] rd_idx;
  always_comb begin
    rd_idx   = (rd_round_i <= 4'd10) ? rd_round_i : 4'd0;
    rd_key_o = '0;
    rd_v_o   = 1'b0;
    if (slot_exists[rd_slot_i]) begin
      rd_key_o = keys[rd_slot_i][rd_idx];
      rd_v_o   = slot_valid_o[rd_slot_i] & (rd_round_i <= 4'd10);
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched with three slots (one index left unpopulated).
// Honours AES_KEY_SCHED_DEFAULT_KEY_EN for the reset-state expectations.
module tb_aes_key_sched;
  localparam int NS = 3;
  localparam int SW = 2;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] A_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] A_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

`ifdef AES_KEY_SCHED_DEFAULT_KEY_EN
  localparam logic [2:0]   RST_SV  = 3'b001;
  localparam logic [127:0] RST_R0  = KEY_A;
  localparam logic [127:0] RST_R10 = A_R10;
  localparam logic         RST_V0  = 1'b1;
`else
  localparam logic [2:0]   RST_SV  = 3'b000;
  localparam logic [127:0] RST_R0  = 128'h0;
  localparam logic [127:0] RST_R10 = 128'h0;
  localparam logic         RST_V0  = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          load_v_i;
  logic [SW-1:0] load_slot_i;
  logic [127:0]  load_key_i;
  logic          load_ready_o;
  logic          busy_o;
  logic [NS-1:0] slot_valid_o;
  logic [SW-1:0] rd_slot_i;
  logic [3:0]    rd_round_i;
  logic [127:0]  rd_key_o;
  logic          rd_v_o;

  int tests  = 0;
  int failed = 0;

  aes_key_sched #(.NUM_SLOTS(NS)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .load_v_i(load_v_i), .load_slot_i(load_slot_i), .load_key_i(load_key_i),
    .load_ready_o(load_ready_o), .busy_o(busy_o), .slot_valid_o(slot_valid_o),
    .rd_slot_i(rd_slot_i), .rd_round_i(rd_round_i),
    .rd_key_o(rd_key_o), .rd_v_o(rd_v_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [SW-1:0] slot;
    logic [3:0]    rnd;
    logic [127:0]  key;
    logic          v;
    string         name;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [SW-1:0] s, input logic [3:0] r,
                    input logic [127:0] ek, input logic ev);
    rd_slot_i  = s;
    rd_round_i = r;
    #1;
    chk({name, "_key"}, rd_key_o, ek);
    chk({name, "_v"}, {127'b0, rd_v_o}, {127'b0, ev});
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic start_load(input logic [SW-1:0] s, input logic [127:0] k);
    load_slot_i = s;
    load_key_i  = k;
    load_v_i    = 1'b1;
    tick();
    load_v_i    = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; load_v_i = 1'b0; load_slot_i = '0; load_key_i = '0;
    rd_slot_i = '0; rd_round_i = '0;

    tbl[0]  = '{2'd0, 4'd0,  KEY_A,   1'b1, "s0_r0"};
    tbl[1]  = '{2'd0, 4'd1,  A_R1,    1'b1, "s0_r1"};
    tbl[2]  = '{2'd0, 4'd5,  A_R5,    1'b1, "s0_r5"};
    tbl[3]  = '{2'd0, 4'd9,  A_R9,    1'b1, "s0_r9"};
    tbl[4]  = '{2'd0, 4'd10, A_R10,   1'b1, "s0_r10"};
    tbl[5]  = '{2'd1, 4'd0,  128'h0,  1'b1, "s1_r0"};
    tbl[6]  = '{2'd1, 4'd1,  Z_R1,    1'b1, "s1_r1"};
    tbl[7]  = '{2'd1, 4'd10, Z_R10,   1'b1, "s1_r10"};
    tbl[8]  = '{2'd0, 4'd12, KEY_A,   1'b0, "s0_r12"};
    tbl[9]  = '{2'd0, 4'd15, KEY_A,   1'b0, "s0_r15"};
    tbl[10] = '{2'd1, 4'd11, 128'h0,  1'b0, "s1_r11"};
    tbl[11] = '{2'd2, 4'd0,  128'h0,  1'b0, "s2_unloaded"};
    tbl[12] = '{2'd3, 4'd5,  128'h0,  1'b0, "s3_oob_r5"};
    tbl[13] = '{2'd3, 4'd0,  128'h0,  1'b0, "s3_oob_r0"};

    // Reset state
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("rst_ready", {127'b0, load_ready_o}, 128'd1);
    chk("rst_busy", {127'b0, busy_o}, 128'd0);
    chk("rst_slot_valid", {125'b0, slot_valid_o}, {125'b0, RST_SV});
    rd("rst_s0_r0", 2'd0, 4'd0, RST_R0, RST_V0);
    rd("rst_s1_r0", 2'd1, 4'd0, 128'h0, 1'b0);
`ifdef AES_KEY_SCHED_DEFAULT_KEY_EN
    rd("rst_default_r9", 2'd0, 4'd9, A_R9, 1'b1);
`endif
    @(negedge clk_i);

    // FIPS-197 key into slot 0, 10-cycle latency to valid
    start_load(2'd0, KEY_A);
    chk("ld0_busy", {127'b0, busy_o}, 128'd1);
    chk("ld0_ready", {127'b0, load_ready_o}, 128'd0);
    chk("ld0_slot_valid", {125'b0, slot_valid_o}, 128'd0);
    rd("ld0_r0_expanding", 2'd0, 4'd0, KEY_A, 1'b0);
    repeat (9) tick();
    chk("ld0_valid_edge9", {127'b0, slot_valid_o[0]}, 128'd0);
    chk("ld0_busy_edge9", {127'b0, busy_o}, 128'd1);
    tick();
    chk("ld0_valid_edge10", {127'b0, slot_valid_o[0]}, 128'd1);
    chk("ld0_ready_edge10", {127'b0, load_ready_o}, 128'd1);
    chk("ld0_busy_edge10", {127'b0, busy_o}, 128'd0);

    // All-zero key into slot 1; slot 0 must be untouched every cycle
    start_load(2'd1, 128'h0);
    for (int i = 0; i < 10; i++) begin
      rd("s0_stable", 2'd0, 4'd10, A_R10, 1'b1);
      tick();
    end
    chk("ld1_slot_valid", {125'b0, slot_valid_o}, 128'd3);

    for (int i = 0; i < 14; i++) rd(tbl[i].name, tbl[i].slot, tbl[i].rnd, tbl[i].key, tbl[i].v);
    @(negedge clk_i);

    // Pulse during expansion is dropped; held request accepted on edge 11
    start_load(2'd2, 128'h0);
    repeat (2) tick();
    load_slot_i = 2'd2; load_key_i = KEY_A; load_v_i = 1'b1;
    tick();
    load_v_i = 1'b0;
    repeat (2) tick();
    load_slot_i = 2'd2; load_key_i = KEY_A; load_v_i = 1'b1;
    repeat (5) tick();
    chk("hold_valid_edge10", {127'b0, slot_valid_o[2]}, 128'd1);
    chk("hold_ready_edge10", {127'b0, load_ready_o}, 128'd1);
    rd("pulse_ignored_r10", 2'd2, 4'd10, Z_R10, 1'b1);
    rd("pulse_ignored_r1", 2'd2, 4'd1, Z_R1, 1'b1);
    tick();
    load_v_i = 1'b0;
    chk("hold_busy_edge11", {127'b0, busy_o}, 128'd1);
    chk("hold_valid_edge11", {127'b0, slot_valid_o[2]}, 128'd0);
    rd("reload_r0", 2'd2, 4'd0, KEY_A, 1'b0);
    rd("reload_old_r10", 2'd2, 4'd10, Z_R10, 1'b0);
    repeat (10) tick();
    chk("reload_slot_valid", {125'b0, slot_valid_o}, 128'd7);
    rd("reload_r10", 2'd2, 4'd10, A_R10, 1'b1);
    rd("reload_r5", 2'd2, 4'd5, A_R5, 1'b1);
    @(negedge clk_i);

    // Reset at round 6 aborts immediately
    start_load(2'd1, KEY_A);
    repeat (6) tick();
    reset_i = 1'b1;
    #1;
    chk("abort_busy", {127'b0, busy_o}, 128'd0);
    chk("abort_ready", {127'b0, load_ready_o}, 128'd1);
    chk("abort_slot_valid", {125'b0, slot_valid_o}, {125'b0, RST_SV});
    rd("abort_s1_r1", 2'd1, 4'd1, 128'h0, 1'b0);
    rd("abort_s0_r10", 2'd0, 4'd10, RST_R10, RST_V0);
    @(negedge clk_i);
    reset_i = 1'b0;
    start_load(2'd0, 128'h0);
    repeat (10) tick();
    chk("post_rst_slot_valid", {125'b0, slot_valid_o}, 128'd1);
    rd("post_rst_s0_r10", 2'd0, 4'd10, Z_R10, 1'b1);
    rd("post_rst_s1_r10", 2'd1, 4'd10, 128'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
